// File: rtl/leds_pwm_ctrl.sv
// leds_pwm_ctrl: memory-mapped LED peripheral with per-LED on/off, optional
// blink and a shared PWM brightness. Four bus registers, all readable:
//   0 DATA      - static on/off per LED
//   1 BLINKMASK - LEDs whose output is gated by the blink phase
//   2 DUTY      - PWM on-time in counter ticks; all ones means fully on
//   3 PERIOD    - blink half-period in PWM frames; 0 disables blinking
// Stage p0 is the counter/register state, stage p1 the registered LED drive.
module leds_pwm_ctrl #(
    parameter int NUM_LEDS   = 16,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 16
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                we_led_i,
    input  logic [1:0]          addr_led_i,
    input  logic [31:0]         dato_led_i,
    output logic [31:0]         dato_led_o,
    output logic [NUM_LEDS-1:0] leds_o
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_BMASK  = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam logic [PWM_BITS-1:0]   DUTY_FULL = '1;
    localparam logic [PWM_BITS-1:0]   PWM_ONE   = PWM_BITS'(1);
    localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);

    // Full duty bypasses the compare so the LED never drops for the
    // single cycle where the counter equals all ones.
    function automatic logic pwm_gate(input logic [PWM_BITS-1:0] cnt,
                                      input logic [PWM_BITS-1:0] duty);
        pwm_gate = (cnt < duty) || (duty == DUTY_FULL);
    endfunction

    // Per-LED blink gate: masked LEDs follow the phase, others pass.
    function automatic logic [NUM_LEDS-1:0] blink_gate(input logic [NUM_LEDS-1:0] mask,
                                                       input logic                phase);
        blink_gate = ~mask | {NUM_LEDS{phase}};
    endfunction

    // ---------------- stage p0: bus registers and counters ----------------
    logic [NUM_LEDS-1:0]   data_q;
    logic [NUM_LEDS-1:0]   blink_mask_q;
    logic [PWM_BITS-1:0]   duty_q;
    logic [BLINK_BITS-1:0] period_q;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic [BLINK_BITS-1:0] blink_cnt_q;
    logic                  blink_phase_q;

    logic wr_data;
    logic wr_bmask;
    logic wr_duty;
    logic wr_period;
    logic frame_tick_p0;
    logic pwm_on_p0;
    logic blink_wrap_p0;

    // Upper write-data bits are deliberately discarded by every register.
    logic unused_din;
    assign unused_din = ^dato_led_i;

    assign wr_data   = we_led_i && (addr_led_i == ADDR_DATA);
    assign wr_bmask  = we_led_i && (addr_led_i == ADDR_BMASK);
    assign wr_duty   = we_led_i && (addr_led_i == ADDR_DUTY);
    assign wr_period = we_led_i && (addr_led_i == ADDR_PERIOD);

    assign frame_tick_p0 = (pwm_cnt_q == '1);
    assign pwm_on_p0     = pwm_gate(pwm_cnt_q, duty_q);
    // Compare before increment, so the counter never exceeds period-1.
    assign blink_wrap_p0 = (blink_cnt_q == period_q - BLINK_ONE);

    // Bus-writable registers; reset leaves LEDs off at full brightness, no blink.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_q       <= '0;
            blink_mask_q <= '0;
            duty_q       <= DUTY_FULL;
            period_q     <= '0;
        end else begin
            if (wr_data) begin
                data_q <= dato_led_i[NUM_LEDS-1:0];
            end
            if (wr_bmask) begin
                blink_mask_q <= dato_led_i[NUM_LEDS-1:0];
            end
            if (wr_duty) begin
                duty_q <= dato_led_i[PWM_BITS-1:0];
            end
            if (wr_period) begin
                period_q <= dato_led_i[BLINK_BITS-1:0];
            end
        end
    end

    // Free-running PWM counter; one frame is 2^PWM_BITS cycles.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
        end
    end

    // Blink timebase counted in frames. A PERIOD write restarts the
    // half-period with the phase on, overriding a coincident frame tick.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (wr_period || (period_q == '0)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (frame_tick_p0) begin
            if (blink_wrap_p0) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_ONE;
            end
        end
    end

    // Combinational readback of the addressed register, zero-extended.
    always_comb begin
        dato_led_o = '0;
        case (addr_led_i)
            ADDR_DATA:   dato_led_o[NUM_LEDS-1:0]   = data_q;
            ADDR_BMASK:  dato_led_o[NUM_LEDS-1:0]   = blink_mask_q;
            ADDR_DUTY:   dato_led_o[PWM_BITS-1:0]   = duty_q;
            default:     dato_led_o[BLINK_BITS-1:0] = period_q;
        endcase
    end

    // ---------------- stage p1: registered LED drive ----------------
    logic [NUM_LEDS-1:0] leds_p1;

    // Combine static enable, PWM and blink into the registered output.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            leds_p1 <= '0;
        end else begin
            leds_p1 <= data_q & {NUM_LEDS{pwm_on_p0}} & blink_gate(blink_mask_q, blink_phase_q);
        end
    end

    assign leds_o = leds_p1;

endmodule
